// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the VGA plot port: grants one sprite requester at a time
// and generates its full pixel burst, suppressing pixels that fall off-screen.
module vga_plot_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int SW_LOG2 = 2,
    parameter int SH_LOG2 = 2,
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 119
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    input  logic [3*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW = IW + 1;
    localparam int CW = SW_LOG2 + SH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_PLOT, S_DONE} state_t;

    state_t                    state, state_nxt;
    logic [IW-1:0]             ptr, owner, win;
    logic [AW-1:0]             scan_idx;
    logic                      found;
    logic [NUM_REQ-1:0]        win_oh;
    logic [NUM_REQ-1:0][7:0]   lane_x;
    logic [NUM_REQ-1:0][6:0]   lane_y;
    logic [NUM_REQ-1:0][2:0]   lane_colour;
    logic [7:0]                win_x, base_x;
    logic [6:0]                win_y, base_y;
    logic [2:0]                win_colour, base_colour;
    logic [CW-1:0]             cnt;
    logic [8:0]                sum_x;
    logic [7:0]                sum_y;
    logic                      in_view;

    // Rotating scan starting at ptr; the first requester found wins.
    always_comb begin
        win      = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, ptr} + AW'(i);
            if (scan_idx >= AW'(NUM_REQ))
                scan_idx = scan_idx - AW'(NUM_REQ);
            if (!found && req[scan_idx[IW-1:0]]) begin
                found = 1'b1;
                win   = scan_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    // Per-requester field extraction, masked by the winner select.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_x[i]      = req_x[8*i +: 8]      & {8{win_oh[i]}};
        assign lane_y[i]      = req_y[7*i +: 7]      & {7{win_oh[i]}};
        assign lane_colour[i] = req_colour[3*i +: 3] & {3{win_oh[i]}};
    end

    always_comb begin
        win_x      = '0;
        win_y      = '0;
        win_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_x      = win_x      | lane_x[i];
            win_y      = win_y      | lane_y[i];
            win_colour = win_colour | lane_colour[i];
        end
    end

    // Sums are one bit wider than the screen so off-edge pixels clip, never wrap.
    assign sum_x   = {1'b0, base_x} + {{(9-SW_LOG2){1'b0}}, cnt[SW_LOG2-1:0]};
    assign sum_y   = {1'b0, base_y} + {{(8-SH_LOG2){1'b0}}, cnt[CW-1:SW_LOG2]};
    assign in_view = (sum_x <= 9'(X_MAX)) && (sum_y <= 8'(Y_MAX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|req) state_nxt = S_PLOT;
            S_PLOT:  if (&cnt) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant       <= '0;
            done        <= '0;
            plot        <= 1'b0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            cnt         <= '0;
            ptr         <= '0;
            owner       <= '0;
            base_x      <= '0;
            base_y      <= '0;
            base_colour <= '0;
        end else begin
            done <= '0;
            plot <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant       <= win_oh;
                        owner       <= win;
                        base_x      <= win_x;
                        base_y      <= win_y;
                        base_colour <= win_colour;
                        cnt         <= '0;
                    end
                end
                S_PLOT: begin
                    cnt    <= cnt + CW'(1);
                    x      <= sum_x[7:0];
                    y      <= sum_y[6:0];
                    colour <= base_colour;
                    plot   <= in_view;
                end
                S_DONE: begin
                    done  <= grant;
                    grant <= '0;
                    ptr   <= (owner == IW'(NUM_REQ-1)) ? '0 : owner + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
